// File: rtl/ahb_lite_2to1_arbiter.sv
// Two-initiator to one-responder AHB-Lite arbiter with a per-initiator address capture register.
// Define CALIPTRA_AHB_ARB_FIXED_PRIO_EN to give initiator 0 fixed priority; round-robin otherwise.
module ahb_lite_2to1_arbiter #(
  parameter int AHB_LITE_ADDR_WIDTH = 32,
  parameter int AHB_LITE_DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [AHB_LITE_ADDR_WIDTH-1:0] m0_haddr,
  input  logic [AHB_LITE_DATA_WIDTH-1:0] m0_hwdata,
  input  logic                           m0_hwrite,
  input  logic [2:0]                     m0_hsize,
  input  logic [1:0]                     m0_htrans,
  output logic [AHB_LITE_DATA_WIDTH-1:0] m0_hrdata,
  output logic                           m0_hreadyout,
  output logic                           m0_hresp,
  input  logic [AHB_LITE_ADDR_WIDTH-1:0] m1_haddr,
  input  logic [AHB_LITE_DATA_WIDTH-1:0] m1_hwdata,
  input  logic                           m1_hwrite,
  input  logic [2:0]                     m1_hsize,
  input  logic [1:0]                     m1_htrans,
  output logic [AHB_LITE_DATA_WIDTH-1:0] m1_hrdata,
  output logic                           m1_hreadyout,
  output logic                           m1_hresp,
  output logic [AHB_LITE_ADDR_WIDTH-1:0] s_haddr,
  output logic [AHB_LITE_DATA_WIDTH-1:0] s_hwdata,
  output logic                           s_hsel,
  output logic                           s_hwrite,
  output logic [2:0]                     s_hsize,
  output logic [1:0]                     s_htrans,
  output logic                           s_hready,
  input  logic [AHB_LITE_DATA_WIDTH-1:0] s_hrdata,
  input  logic                           s_hreadyout,
  input  logic                           s_hresp
);
  localparam int AW = AHB_LITE_ADDR_WIDTH;

  logic [AW-1:0] m_haddr   [2];
  logic          m_hwrite  [2];
  logic [2:0]    m_hsize   [2];
  logic [1:0]    live;
  logic          unused_htrans;

  assign m_haddr[0]  = m0_haddr;
  assign m_haddr[1]  = m1_haddr;
  assign m_hwrite[0] = m0_hwrite;
  assign m_hwrite[1] = m1_hwrite;
  assign m_hsize[0]  = m0_hsize;
  assign m_hsize[1]  = m1_hsize;
  // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
  assign live          = {m1_htrans[1], m0_htrans[1]};
  assign unused_htrans = m0_htrans[0] ^ m1_htrans[0];

  logic          owner_vld_q, owner_q;
  logic [AW-1:0] haddr_q;
  logic          hwrite_q;
  logic [2:0]    hsize_q;

  logic [1:0]    pend_vld;
  logic [AW-1:0] pend_addr  [2];
  logic          pend_write [2];
  logic [2:0]    pend_size  [2];

  logic [1:0]    req, granted, capture, hready_vec, hresp_vec;
  logic          bus_ready, grant_vld, grant;
  logic [AW-1:0] addr_sel;
  logic          write_sel;
  logic [2:0]    size_sel;

  assign req       = pend_vld | live;
  assign bus_ready = owner_vld_q ? s_hreadyout : 1'b1;
  assign grant_vld = bus_ready & (|req);

`ifdef CALIPTRA_AHB_ARB_FIXED_PRIO_EN
  assign grant = ~req[0];
`else
  logic last_grant_q, last_grant_d;

  assign grant        = (&req) ? ~last_grant_q : req[1];
  assign last_grant_d = grant_vld ? grant : last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    addr_sel  = m_haddr[grant];
    write_sel = m_hwrite[grant];
    size_sel  = m_hsize[grant];
    if (pend_vld[grant]) begin
      addr_sel  = pend_addr[grant];
      write_sel = pend_write[grant];
      size_sel  = pend_size[grant];
    end
  end

  // Address/control hold their last driven value while no transfer is issued.
  assign s_hsel   = grant_vld;
  assign s_htrans = grant_vld ? 2'b10 : 2'b00;
  assign s_haddr  = grant_vld ? addr_sel  : haddr_q;
  assign s_hwrite = grant_vld ? write_sel : hwrite_q;
  assign s_hsize  = grant_vld ? size_sel  : hsize_q;
  assign s_hready = bus_ready;
  assign s_hwdata = owner_q ? m1_hwdata : m0_hwdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_vld_q <= 1'b0;
      owner_q     <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
    end else if (bus_ready) begin
      owner_vld_q <= grant_vld;
      owner_q     <= grant;
      if (grant_vld) begin
        haddr_q  <= addr_sel;
        hwrite_q <= write_sel;
        hsize_q  <= size_sel;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_init
    logic          is_owner;
    logic          pend_vld_q, pend_vld_d;
    logic [AW-1:0] pend_addr_q;
    logic          pend_write_q;
    logic [2:0]    pend_size_q;

    assign is_owner    = owner_vld_q & (owner_q == 1'(gi));
    assign granted[gi] = grant_vld & (grant == 1'(gi));
    // Data phase finishing while a new, losing address is presented: accept it into the capture register.
    assign capture[gi] = is_owner & s_hreadyout & live[gi] & ~granted[gi];

    assign hready_vec[gi] = is_owner                     ? s_hreadyout :
                            pend_vld_q                   ? 1'b0 :
                            (live[gi] & ~granted[gi])    ? 1'b0 : 1'b1;
    assign hresp_vec[gi]  = is_owner & s_hresp;

    assign pend_vld_d = capture[gi] ? 1'b1 :
                        (granted[gi] & pend_vld_q) ? 1'b0 : pend_vld_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_vld_q   <= 1'b0;
        pend_addr_q  <= '0;
        pend_write_q <= 1'b0;
        pend_size_q  <= '0;
      end else begin
        pend_vld_q <= pend_vld_d;
        if (capture[gi]) begin
          pend_addr_q  <= m_haddr[gi];
          pend_write_q <= m_hwrite[gi];
          pend_size_q  <= m_hsize[gi];
        end
      end
    end

    assign pend_vld[gi]   = pend_vld_q;
    assign pend_addr[gi]  = pend_addr_q;
    assign pend_write[gi] = pend_write_q;
    assign pend_size[gi]  = pend_size_q;
  end

  assign m0_hrdata    = s_hrdata;
  assign m1_hrdata    = s_hrdata;
  assign m0_hreadyout = hready_vec[0];
  assign m1_hreadyout = hready_vec[1];
  assign m0_hresp     = hresp_vec[0];
  assign m1_hresp     = hresp_vec[1];

endmodule

// File: tb/tb_ahb_lite_2to1_arbiter.sv
// Directed self-checking bench for ahb_lite_2to1_arbiter; expectations are hand-computed per cycle.
module tb_ahb_lite_2to1_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_haddr, m0_hwdata, m0_hrdata, m1_haddr, m1_hwdata, m1_hrdata;
  logic        m0_hwrite, m0_hreadyout, m0_hresp, m1_hwrite, m1_hreadyout, m1_hresp;
  logic [2:0]  m0_hsize, m1_hsize, s_hsize;
  logic [1:0]  m0_htrans, m1_htrans, s_htrans;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hsel, s_hwrite, s_hready, s_hreadyout, s_hresp;

  int check_cnt = 0;
  int err_cnt   = 0;

  always #5 clk = ~clk;

  ahb_lite_2to1_arbiter #(
    .AHB_LITE_ADDR_WIDTH(32),
    .AHB_LITE_DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_haddr(m0_haddr), .m0_hwdata(m0_hwdata), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_htrans(m0_htrans), .m0_hrdata(m0_hrdata), .m0_hreadyout(m0_hreadyout), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwdata(m1_hwdata), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_htrans(m1_htrans), .m1_hrdata(m1_hrdata), .m1_hreadyout(m1_hreadyout), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwdata(s_hwdata), .s_hsel(s_hsel), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_htrans(s_htrans), .s_hready(s_hready),
    .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int n, input logic [1:0] trans, input logic [31:0] addr, input logic wr);
    if (n == 0) begin
      m0_htrans = trans; m0_haddr = addr; m0_hwrite = wr; m0_hsize = 3'b010;
    end else begin
      m1_htrans = trans; m1_haddr = addr; m1_hwrite = wr; m1_hsize = 3'b010;
    end
  endtask

  task automatic resp(input logic rdy, input logic err, input logic [31:0] rdata);
    s_hreadyout = rdy; s_hresp = err; s_hrdata = rdata;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 2'b00, 32'h0, 1'b0);
    drive(1, 2'b00, 32'h0, 1'b0);
    m0_hwdata = '0; m1_hwdata = '0;
    resp(1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  logic [31:0] exp_addr [4];
  logic        exp_m1_rdy [4];

  initial begin
    // Reset state
    drive(0, 2'b00, 32'h0, 1'b0);
    drive(1, 2'b00, 32'h0, 1'b0);
    m0_hwdata = '0; m1_hwdata = '0;
    resp(1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_htrans", 32'(s_htrans), 32'd0);
    check_eq("rst_hsel", 32'(s_hsel), 32'd0);
    check_eq("rst_hready", 32'(s_hready), 32'd1);
    check_eq("rst_m0_rdy", 32'(m0_hreadyout), 32'd1);
    check_eq("rst_m1_rdy", 32'(m1_hreadyout), 32'd1);
    check_eq("rst_m0_resp", 32'(m0_hresp), 32'd0);
    check_eq("rst_m1_resp", 32'(m1_hresp), 32'd0);
    check_eq("rst_haddr", s_haddr, 32'h0);
    advance();
    rst = 1'b0;

    // m0 single write, one responder wait state
    $display("txn: m0 write 0x00001000 data 0xa5a5a5a5");
    drive(0, 2'b10, 32'h1000, 1'b1);
    @(negedge clk);
    check_eq("wr_haddr", s_haddr, 32'h1000);
    check_eq("wr_hsel", 32'(s_hsel), 32'd1);
    check_eq("wr_htrans", 32'(s_htrans), 32'd2);
    check_eq("wr_hwrite", 32'(s_hwrite), 32'd1);
    check_eq("wr_m0_rdy_addr", 32'(m0_hreadyout), 32'd1);
    advance();
    drive(0, 2'b00, 32'h0, 1'b0);
    m0_hwdata = 32'hA5A5A5A5;
    resp(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("wr_hwdata", s_hwdata, 32'hA5A5A5A5);
    check_eq("wr_m0_rdy_wait", 32'(m0_hreadyout), 32'd0);
    check_eq("wr_hready_wait", 32'(s_hready), 32'd0);
    check_eq("wr_hsel_wait", 32'(s_hsel), 32'd0);
    check_eq("wr_haddr_hold", s_haddr, 32'h1000);
    advance();
    resp(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("wr_m0_rdy_done", 32'(m0_hreadyout), 32'd1);
    check_eq("wr_hwdata_done", s_hwdata, 32'hA5A5A5A5);
    advance();

    // Simultaneous requests after reset: m0 first
    do_reset();
    $display("txn: m0 read 0x00000010 and m1 read 0x00000020 together");
    drive(0, 2'b10, 32'h10, 1'b0);
    drive(1, 2'b10, 32'h20, 1'b0);
    @(negedge clk);
    check_eq("tie_haddr0", s_haddr, 32'h10);
    check_eq("tie_m0_rdy", 32'(m0_hreadyout), 32'd1);
    check_eq("tie_m1_rdy", 32'(m1_hreadyout), 32'd0);
    advance();
    drive(0, 2'b00, 32'h0, 1'b0);
    resp(1'b1, 1'b0, 32'h11110000);
    @(negedge clk);
    check_eq("tie_m0_rdata", m0_hrdata, 32'h11110000);
    check_eq("tie_m0_rdy_data", 32'(m0_hreadyout), 32'd1);
    check_eq("tie_haddr1", s_haddr, 32'h20);
    check_eq("tie_hsel1", 32'(s_hsel), 32'd1);
    check_eq("tie_m1_rdy_addr", 32'(m1_hreadyout), 32'd1);
    advance();
    drive(1, 2'b00, 32'h0, 1'b0);
    resp(1'b1, 1'b0, 32'h22220000);
    @(negedge clk);
    check_eq("tie_m1_rdata", m1_hrdata, 32'h22220000);
    check_eq("tie_m1_rdy_data", 32'(m1_hreadyout), 32'd1);
    check_eq("tie_m0_resp", 32'(m0_hresp), 32'd0);
    advance();

    // Capture: m0 0x0, 0x4 pipelined while m1 requests 0x100
    do_reset();
    $display("txn: m0 reads 0x0,0x4 with m1 read 0x100 in between");
    drive(0, 2'b10, 32'h0, 1'b0);
    @(negedge clk);
    check_eq("cap_haddr_a", s_haddr, 32'h0);
    advance();
    drive(0, 2'b11, 32'h4, 1'b0);
    drive(1, 2'b10, 32'h100, 1'b0);
    resp(1'b1, 1'b0, 32'h000000D0);
    @(negedge clk);
    check_eq("cap_haddr_b", s_haddr, 32'h100);
    check_eq("cap_m0_rdy_b", 32'(m0_hreadyout), 32'd1);
    check_eq("cap_m1_rdy_b", 32'(m1_hreadyout), 32'd1);
    check_eq("cap_m0_rdata", m0_hrdata, 32'h000000D0);
    check_eq("cap_htrans_b", 32'(s_htrans), 32'd2);
    advance();
    drive(0, 2'b00, 32'h0, 1'b0);
    drive(1, 2'b00, 32'h0, 1'b0);
    resp(1'b1, 1'b0, 32'h0000D100);
    @(negedge clk);
    check_eq("cap_haddr_c", s_haddr, 32'h4);
    check_eq("cap_hsel_c", 32'(s_hsel), 32'd1);
    check_eq("cap_htrans_c", 32'(s_htrans), 32'd2);
    check_eq("cap_m0_rdy_c", 32'(m0_hreadyout), 32'd0);
    check_eq("cap_m1_rdy_c", 32'(m1_hreadyout), 32'd1);
    advance();
    resp(1'b1, 1'b0, 32'h000000D4);
    @(negedge clk);
    check_eq("cap_m0_rdy_d", 32'(m0_hreadyout), 32'd1);
    check_eq("cap_hsel_d", 32'(s_hsel), 32'd0);
    advance();

    // Responder wait states on an m1 read while m0 requests
    $display("txn: m1 read 0x200 with 3 wait states, m0 read 0x300 waiting");
    drive(1, 2'b10, 32'h200, 1'b0);
    @(negedge clk);
    check_eq("ws_haddr", s_haddr, 32'h200);
    check_eq("ws_m1_rdy_addr", 32'(m1_hreadyout), 32'd1);
    advance();
    drive(1, 2'b00, 32'h0, 1'b0);
    drive(0, 2'b10, 32'h300, 1'b0);
    for (int i = 0; i < 3; i++) begin
      resp(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check_eq($sformatf("ws_m1_rdy_%0d", i), 32'(m1_hreadyout), 32'd0);
      check_eq($sformatf("ws_m0_rdy_%0d", i), 32'(m0_hreadyout), 32'd0);
      check_eq($sformatf("ws_hsel_%0d", i), 32'(s_hsel), 32'd0);
      advance();
    end
    resp(1'b1, 1'b0, 32'h33334444);
    @(negedge clk);
    check_eq("ws_m1_rdy_done", 32'(m1_hreadyout), 32'd1);
    check_eq("ws_m1_rdata", m1_hrdata, 32'h33334444);
    check_eq("ws_hsel_m0", 32'(s_hsel), 32'd1);
    check_eq("ws_haddr_m0", s_haddr, 32'h300);
    check_eq("ws_m0_rdy_addr", 32'(m0_hreadyout), 32'd1);
    advance();
    drive(0, 2'b00, 32'h0, 1'b0);
    resp(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("ws_m0_rdy_done", 32'(m0_hreadyout), 32'd1);
    advance();

    // Two-cycle ERROR on an m0 write
    $display("txn: m0 write 0x400 answered with ERROR");
    drive(0, 2'b10, 32'h400, 1'b1);
    @(negedge clk);
    check_eq("err_haddr", s_haddr, 32'h400);
    advance();
    drive(0, 2'b00, 32'h0, 1'b0);
    m0_hwdata = 32'hDEADBEEF;
    resp(1'b0, 1'b1, 32'h0);
    @(negedge clk);
    check_eq("err1_m0_resp", 32'(m0_hresp), 32'd1);
    check_eq("err1_m0_rdy", 32'(m0_hreadyout), 32'd0);
    check_eq("err1_m1_resp", 32'(m1_hresp), 32'd0);
    check_eq("err1_hwdata", s_hwdata, 32'hDEADBEEF);
    advance();
    resp(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    check_eq("err2_m0_resp", 32'(m0_hresp), 32'd1);
    check_eq("err2_m0_rdy", 32'(m0_hreadyout), 32'd1);
    check_eq("err2_m1_resp", 32'(m1_hresp), 32'd0);
    advance();
    resp(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("err3_m0_resp", 32'(m0_hresp), 32'd0);
    advance();

    // Continuous contention from both initiators
`ifdef CALIPTRA_AHB_ARB_FIXED_PRIO_EN
    exp_addr   = '{32'hA0, 32'hA0, 32'hA0, 32'hA0};
    exp_m1_rdy = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_addr   = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
    exp_m1_rdy = '{1'b0, 1'b1, 1'b1, 1'b0};
`endif
    do_reset();
    drive(0, 2'b10, 32'hA0, 1'b0);
    drive(1, 2'b10, 32'hB0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      $display("txn: contention cycle %0d issues 0x%08h", i, s_haddr);
      check_eq($sformatf("cont_haddr_%0d", i), s_haddr, exp_addr[i]);
      check_eq($sformatf("cont_m1_rdy_%0d", i), 32'(m1_hreadyout), 32'(exp_m1_rdy[i]));
      check_eq($sformatf("cont_hsel_%0d", i), 32'(s_hsel), 32'd1);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_lite_2to1_arbiter.md
Name: ahb_lite_2to1_arbiter

Overview:
- Two-initiator to one-responder AHB-Lite arbiter.
- Lets two AHB-Lite initiators (e.g. core LSU and DMA) share one responder-side bus segment ahead of the existing AHB-Lite address decoder.
- Arbitrates address phases round-robin, tracks the data-phase owner, and routes hwdata, hrdata, hresp and hreadyout.
- Holds one address-phase capture register per initiator so a completed data phase never forces a lost address phase.

Parameters:
- AHB_LITE_ADDR_WIDTH, 32, address width on all ports.
- AHB_LITE_DATA_WIDTH, 32, read/write data width on all ports.

Ports:
- clk  input  1  bus clock.
- rst  input  1  asynchronous active-high reset.
- mN_haddr  input  ADDR_W  initiator N (N=0,1) address.
- mN_hwdata  input  DATA_W  initiator N write data.
- mN_hwrite  input  1  initiator N write flag.
- mN_hsize  input  3  initiator N size.
- mN_htrans  input  2  initiator N transfer type.
- mN_hrdata  output  DATA_W  read data to initiator N.
- mN_hreadyout  output  1  ready to initiator N.
- mN_hresp  output  1  response to initiator N.
- s_haddr  output  ADDR_W  responder address.
- s_hwdata  output  DATA_W  responder write data.
- s_hsel  output  1  responder select.
- s_hwrite  output  1  responder write flag.
- s_hsize  output  3  responder size.
- s_htrans  output  2  responder transfer type.
- s_hready  output  1  bus-level ready to responder.
- s_hrdata  input  DATA_W  responder read data.
- s_hreadyout  input  1  responder ready.
- s_hresp  input  1  responder response.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: owner_vld=0, pend_vld0=pend_vld1=0, last_grant=1 (so initiator 0 wins first), pending address/control registers 0.
- Live request: liveN = mN_htrans[1] (NONSEQ or SEQ). IDLE and BUSY are not requests.
- Request: reqN = pend_vldN | liveN.
- s_hready = owner_vld ? s_hreadyout : 1.
- Arbitration: evaluated only when s_hready=1.
  - Round-robin between requesters: the initiator not equal to last_grant wins a tie; a lone requester wins.
  - Grant updates last_grant.
- Granted initiator G drives the responder address phase:
  - s_hsel=1, s_htrans=2'b10 (NONSEQ always; SEQ downgraded).
  - s_haddr/s_hwrite/s_hsize come from G's pending register if pend_vldG, else from G's live inputs.
  - No grant, or s_hready=0: s_hsel=0, s_htrans=2'b00; s_haddr/s_hwrite/s_hsize hold their last driven values (0 after reset).
- On the clock edge where s_hready=1: owner_vld <= grant_valid, owner <= G. If G used its pending register, pend_vldG <= 0.
- Data phase routing:
  - s_hwdata = m{owner}_hwdata.
  - mN_hrdata = s_hrdata (broadcast).
  - mN_hresp = (owner_vld & owner==N) ? s_hresp : 0.
- mN_hreadyout, by priority:
  1. owner_vld & owner==N: s_hreadyout.
  2. pend_vldN: 0 (N is waiting in the data phase of its captured transfer).
  3. liveN & not granted this cycle: 0 (N holds its address; no capture).
  4. Otherwise: 1.
- Capture: when owner==N, s_hreadyout=1, liveN=1 and N is not granted this cycle, latch mN_haddr/hwrite/hsize into N's pending register and set pend_vldN=1. N's hreadyout=1 in that cycle, so the address is accepted.
- A pended write's hwdata is held stable by N because its hreadyout stays 0 until the pended data phase completes.
- Error response:
  - A two-cycle ERROR (s_hreadyout=0/s_hresp=1, then 1/1) passes to the owner only.
  - A capture during the second ERROR cycle is allowed: the initiator may cancel with IDLE, but a pended transfer is still issued (AHB-Lite permits this).
- Simultaneous events: both initiators pending plus one live is impossible (max one outstanding per initiator). Grant and capture in the same cycle for different initiators is legal.
- Reset mid-transfer: all state clears immediately; the responder sees IDLE, and in-flight transfers are dropped.
- Latency: uncontended transfer is zero added cycles. A captured transfer adds one address cycle.

Optional Feature:
- Macro: CALIPTRA_AHB_ARB_FIXED_PRIO_EN.
- Defined: initiator 0 always wins contention; last_grant is unused and removed.
- Undefined: round-robin as above.
- All other behaviour is identical in both cases.

Test Plan:
- Reset → s_htrans=0, s_hsel=0, s_hready=1, m0/m1_hreadyout=1, m0/m1_hresp=0, no pending.
- m0 single write 0x1000 data 0xA5A5A5A5, m1 idle → s_haddr=0x1000 same cycle, s_hwdata=0xA5A5A5A5 next cycle, m0_hreadyout follows s_hreadyout.
- Both NONSEQ same cycle after reset (m0 0x10, m1 0x20) → m0 granted first, m1_hreadyout=0; m1 issued the next s_hready cycle; each read returns its own data.
- m0 back-to-back reads 0x0,0x4 while m1 requests 0x100 → 0x4 captured (pend_vld0=1), order on bus 0x0,0x100,0x4; m0_hreadyout low until 0x4 data completes.
- Responder wait states (s_hreadyout low 3 cycles) on m1 read → m1_hreadyout low 3 cycles, m0 stalled, no new s_hsel during the wait.
- ERROR on m0 write → m0_hresp 1 for two cycles with hreadyout 0 then 1; m1_hresp stays 0.
- With CALIPTRA_AHB_ARB_FIXED_PRIO_EN, continuous m0 and m1 requests → m0 granted every arbitration.
